// File: rtl/wb_regfile.sv
// wb_regfile: writeback-select mux and architectural integer register file
// (x1..x31) for the 5-stage RV32I core, plus a registered last-write trace
// and a commit counter used by the compliance bench.
//
// Optional feature: define WB_REGFILE_BYPASS_EN to make a same-cycle read of
// the register being committed return the writeback value (write-through).
// Without it, reads return the pre-write array contents.
module wb_regfile #(
    parameter int XLEN    = 32,
    parameter int COUNT_W = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [4:0]         IN_INSTRUCTION,
    input  logic [XLEN-1:0]    IN_PC_4,
    input  logic [XLEN-1:0]    IN_ALU_RESULT,
    input  logic [XLEN-1:0]    IN_IMMEDIATE,
    input  logic [XLEN-1:0]    IN_DMEM_OUT,
    input  logic [1:0]         IN_WB_SEL,
    input  logic               IN_REG_WRITE_EN,
    input  logic [4:0]         IN_RS1_ADDR,
    input  logic [4:0]         IN_RS2_ADDR,
    output logic [XLEN-1:0]    OUT_RS1_DATA,
    output logic [XLEN-1:0]    OUT_RS2_DATA,
    output logic [XLEN-1:0]    OUT_WB_DATA,
    output logic [4:0]         OUT_LAST_RD,
    output logic [XLEN-1:0]    OUT_LAST_DATA,
    output logic [COUNT_W-1:0] OUT_WB_COUNT
);

    // Entry 0 exists only to keep indexing in range; it is never written
    // and reads of address 0 are forced to zero anyway.
    logic [XLEN-1:0]    regs [0:31];
    logic [XLEN-1:0]    wb_data;
    logic               commit;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [4:0]         last_rd;
    logic [XLEN-1:0]    last_data;
    logic [COUNT_W-1:0] wb_count;

    // Writeback source select; independent of the write enable so EX can
    // forward it regardless of whether the instruction commits.
    always_comb begin
        wb_data = IN_ALU_RESULT;
        case (IN_WB_SEL)
            2'b00:   wb_data = IN_ALU_RESULT;
            2'b01:   wb_data = IN_DMEM_OUT;
            2'b10:   wb_data = IN_PC_4;
            default: wb_data = IN_IMMEDIATE;
        endcase
    end

    // A write commits only on a clean enable to a nonzero rd. Gating with
    // RST keeps the write-through path quiet while reset is held, so the
    // read ports stay at zero during reset.
    assign commit = (IN_REG_WRITE_EN == 1'b1) && (IN_INSTRUCTION != 5'd0) && !RST;

    // Register array: cleared asynchronously, written on each commit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[IN_INSTRUCTION] <= wb_data;
        end
    end

    // Read port 1: x0 hardwired to zero, optional write-through.
    always_comb begin
        rs1_data = '0;
        if (IN_RS1_ADDR != 5'd0) begin
            rs1_data = regs[IN_RS1_ADDR];
        end
`ifdef WB_REGFILE_BYPASS_EN
        if (commit && (IN_RS1_ADDR == IN_INSTRUCTION)) begin
            rs1_data = wb_data;
        end
`endif
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        rs2_data = '0;
        if (IN_RS2_ADDR != 5'd0) begin
            rs2_data = regs[IN_RS2_ADDR];
        end
`ifdef WB_REGFILE_BYPASS_EN
        if (commit && (IN_RS2_ADDR == IN_INSTRUCTION)) begin
            rs2_data = wb_data;
        end
`endif
    end

    // Last-write trace: captures rd and data of every commit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_rd   <= '0;
            last_data <= '0;
        end else if (commit) begin
            last_rd   <= IN_INSTRUCTION;
            last_data <= wb_data;
        end
    end

    // Commit counter; wraps silently at 2^COUNT_W.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_count <= '0;
        end else if (commit) begin
            wb_count <= wb_count + COUNT_W'(1);
        end
    end

    assign OUT_WB_DATA   = wb_data;
    assign OUT_RS1_DATA  = rs1_data;
    assign OUT_RS2_DATA  = rs2_data;
    assign OUT_LAST_RD   = last_rd;
    assign OUT_LAST_DATA = last_data;
    assign OUT_WB_COUNT  = wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: a default-width instance plus a
// COUNT_W=4 instance (shared stimulus) to exercise counter wrap.
module tb_wb_regfile;

    logic        CLK;
    logic        RST;
    logic [4:0]  rd;
    logic [31:0] pc4, alu, imm, dmem;
    logic [1:0]  sel;
    logic        en;
    logic [4:0]  rs1, rs2;

    logic [31:0] rs1_data, rs2_data, wb_data, last_data;
    logic [4:0]  last_rd;
    logic [31:0] wb_count;

    logic [31:0] w_rs1_data, w_rs2_data, w_wb_data, w_last_data;
    logic [4:0]  w_last_rd;
    logic [3:0]  w_wb_count;

    int compared;
    int mismatched;

    wb_regfile dut (
        .CLK(CLK), .RST(RST), .IN_INSTRUCTION(rd), .IN_PC_4(pc4),
        .IN_ALU_RESULT(alu), .IN_IMMEDIATE(imm), .IN_DMEM_OUT(dmem),
        .IN_WB_SEL(sel), .IN_REG_WRITE_EN(en), .IN_RS1_ADDR(rs1),
        .IN_RS2_ADDR(rs2), .OUT_RS1_DATA(rs1_data), .OUT_RS2_DATA(rs2_data),
        .OUT_WB_DATA(wb_data), .OUT_LAST_RD(last_rd),
        .OUT_LAST_DATA(last_data), .OUT_WB_COUNT(wb_count)
    );

    wb_regfile #(.XLEN(32), .COUNT_W(4)) dut_w (
        .CLK(CLK), .RST(RST), .IN_INSTRUCTION(rd), .IN_PC_4(pc4),
        .IN_ALU_RESULT(alu), .IN_IMMEDIATE(imm), .IN_DMEM_OUT(dmem),
        .IN_WB_SEL(sel), .IN_REG_WRITE_EN(en), .IN_RS1_ADDR(rs1),
        .IN_RS2_ADDR(rs2), .OUT_RS1_DATA(w_rs1_data), .OUT_RS2_DATA(w_rs2_data),
        .OUT_WB_DATA(w_wb_data), .OUT_LAST_RD(w_last_rd),
        .OUT_LAST_DATA(w_last_data), .OUT_WB_COUNT(w_wb_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic        en;
        logic [31:0] alu, dmem, pc4, imm;
        logic [4:0]  rs1, rs2;
        logic [31:0] exp_wb, exp_rs1, exp_rs2, exp_cnt;
        logic [4:0]  exp_last_rd;
        logic [31:0] exp_last_data;
    } vec_t;

    vec_t vecs [9];

    initial begin
        compared   = 0;
        mismatched = 0;

        // T2 mux: x5 through all four sources
        vecs[0] = '{5'd5, 2'b00, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44000000, 5'd5, 5'd5,
                    32'h11, 32'h11, 32'h11, 32'd1, 5'd5, 32'h11};
        vecs[1] = '{5'd5, 2'b01, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44000000, 5'd5, 5'd5,
                    32'h22, 32'h22, 32'h22, 32'd2, 5'd5, 32'h22};
        vecs[2] = '{5'd5, 2'b10, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44000000, 5'd5, 5'd5,
                    32'h33, 32'h33, 32'h33, 32'd3, 5'd5, 32'h33};
        vecs[3] = '{5'd5, 2'b11, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44000000, 5'd5, 5'd5,
                    32'h44000000, 32'h44000000, 32'h44000000, 32'd4, 5'd5, 32'h44000000};
        // T3 x0 write ignored
        vecs[4] = '{5'd0, 2'b00, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5,
                    32'hDEADBEEF, 32'h0, 32'h44000000, 32'd4, 5'd5, 32'h44000000};
        // T5 enable low
        vecs[5] = '{5'd9, 2'b00, 1'b0, 32'h1234, 32'h0, 32'h0, 32'h0, 5'd9, 5'd5,
                    32'h1234, 32'h0, 32'h44000000, 32'd4, 5'd5, 32'h44000000};
        // ordinary commits to different registers, including x31 and x1
        vecs[6] = '{5'd9, 2'b00, 1'b1, 32'h1234, 32'h0, 32'h0, 32'h0, 5'd9, 5'd5,
                    32'h1234, 32'h1234, 32'h44000000, 32'd5, 5'd9, 32'h1234};
        vecs[7] = '{5'd31, 2'b01, 1'b1, 32'h0, 32'hFFFFFF80, 32'h0, 32'h0, 5'd31, 5'd9,
                    32'hFFFFFF80, 32'hFFFFFF80, 32'h1234, 32'd6, 5'd31, 32'hFFFFFF80};
        vecs[8] = '{5'd1, 2'b10, 1'b1, 32'h0, 32'h0, 32'h104, 32'h0, 5'd1, 5'd31,
                    32'h104, 32'h104, 32'hFFFFFF80, 32'd7, 5'd1, 32'h104};

        // reset state
        RST = 1'b1; rd = 0; pc4 = 0; alu = 0; imm = 0; dmem = 0; sel = 0; en = 0;
        rs1 = 5'd5; rs2 = 5'd31;
        #1;
        check("reset_count", wb_count, 32'd0);
        check("reset_last_rd", {27'd0, last_rd}, 32'd0);
        check("reset_last_data", last_data, 32'd0);
        check("reset_rs1", rs1_data, 32'd0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;

        // table-driven vectors
        for (int i = 0; i < 9; i++) begin
            rd = vecs[i].rd; sel = vecs[i].sel; en = vecs[i].en;
            alu = vecs[i].alu; dmem = vecs[i].dmem; pc4 = vecs[i].pc4; imm = vecs[i].imm;
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
            #1;
            check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].exp_wb);
            @(posedge CLK); #1;
            check($sformatf("v%0d_rs1", i), rs1_data, vecs[i].exp_rs1);
            check($sformatf("v%0d_rs2", i), rs2_data, vecs[i].exp_rs2);
            check($sformatf("v%0d_count", i), wb_count, vecs[i].exp_cnt);
            check($sformatf("v%0d_last_rd", i), {27'd0, last_rd}, {27'd0, vecs[i].exp_last_rd});
            check($sformatf("v%0d_last_data", i), last_data, vecs[i].exp_last_data);
        end

        // T4: seed x7 = 0x55, then same-cycle read of a commit to x7
        rd = 5'd7; sel = 2'b00; en = 1'b1; alu = 32'h55; rs1 = 5'd7; rs2 = 5'd7;
        @(posedge CLK); #1;
        check("t4_seed", rs1_data, 32'h55);
        alu = 32'hCAFE;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        check("t4_same_rs1", rs1_data, 32'hCAFE);
        check("t4_same_rs2", rs2_data, 32'hCAFE);
`else
        check("t4_same_rs1", rs1_data, 32'h55);
        check("t4_same_rs2", rs2_data, 32'h55);
`endif
        @(posedge CLK); #1;
        en = 1'b0;
        #1;
        check("t4_next_rs1", rs1_data, 32'hCAFE);
        check("t4_next_rs2", rs2_data, 32'hCAFE);
        check("t4_count", wb_count, 32'd9);

        // T1: async reset mid-run with a write pending across the edge
        en = 1'b1; rd = 5'd7; alu = 32'hBEEF; rs1 = 5'd7; rs2 = 5'd5;
        @(posedge CLK); #3;
        RST = 1'b1;
        #1;
        check("t1_async_count", wb_count, 32'd0);
        check("t1_async_last_rd", {27'd0, last_rd}, 32'd0);
        check("t1_async_rs1", rs1_data, 32'd0);
        check("t1_async_rs2", rs2_data, 32'd0);
        @(posedge CLK); #1;
        check("t1_held_count", wb_count, 32'd0);
        check("t1_held_rs1", rs1_data, 32'd0);
        check("t1_held_last_data", last_data, 32'd0);
        en = 1'b0;
        RST = 1'b0;
        #1;
        check("t1_after_rs1", rs1_data, 32'd0);

        // T6: 17 commits; 4-bit counter wraps to 1
        sel = 2'b00; en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rd  = 5'((i % 31) + 1);
            alu = 32'(i) * 32'h101 + 32'h1;
            @(posedge CLK); #1;
        end
        en = 1'b0; rs1 = 5'd17; rs2 = 5'd1;
        #1;
        check("t6_w_count", {28'd0, w_wb_count}, 32'd1);
        check("t6_count", wb_count, 32'd17);
        check("t6_w_last_rd", {27'd0, w_last_rd}, 32'd17);
        check("t6_w_last_data", w_last_data, 32'h1011);
        check("t6_last_data", last_data, 32'h1011);
        check("t6_rs1", rs1_data, 32'h1011);
        check("t6_rs2", rs2_data, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
